// File: rtl/pn_seq_ctrl_pkg.sv
// Shared FSM encoding and power-on defaults for the PN chip sequencer.
package pn_seq_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam logic [3:0] PN_DEF_SEED = 4'b0110;
    localparam logic [3:0] PN_DEF_TAPS = 4'b1001;

endpackage

// File: rtl/pn_lfsr.sv
// Fibonacci shift/feedback register: load wins over advance; one step per advance, holds otherwise.
// Feedback is the XOR of the tapped bits, shifted in at the MSB; chip is taken from bit 0.
module pn_lfsr #(
    parameter int                LFSR_W  = 4,
    parameter logic [LFSR_W-1:0] RST_VAL = 4'b0110
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              load,
    input  logic [LFSR_W-1:0] seed,
    input  logic              advance,
    input  logic [LFSR_W-1:0] taps,
    output logic [LFSR_W-1:0] state
);

    logic [LFSR_W-1:0] state_q;
    logic [LFSR_W-1:0] state_d;

    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = seed;
        end else if (advance) begin
            state_d = {^(state_q & taps), state_q[LFSR_W-1:1]};
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q <= RST_VAL;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/pn_seq_ctrl.sv
// PN burst sequencer: start -> LOAD -> first chip valid two edges after start; chips advance only on
// chip_valid & chip_ready, so backpressure freezes chip and flags; config accepted only while idle.
module pn_seq_ctrl
    import pn_seq_ctrl_pkg::*;
#(
    parameter int                LFSR_W   = 4,
    parameter int                CNT_W    = 16,
    parameter logic [LFSR_W-1:0] DEF_SEED = PN_DEF_SEED,
    parameter logic [LFSR_W-1:0] DEF_TAPS = PN_DEF_TAPS
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [LFSR_W-1:0] cfg_seed,
    input  logic [LFSR_W-1:0] cfg_taps,
    input  logic [CNT_W-1:0]  cfg_len,
    input  logic              start,
    input  logic              abort,
    output logic              chip_out,
    output logic              chip_valid,
    input  logic              chip_ready,
    output logic              period_mark,
    output logic              burst_last,
    output logic              busy,
    output logic              done,
    output logic              err_seed_zero
);

    state_e            state_q, state_d;
    logic [LFSR_W-1:0] seed_q, seed_d;
    logic [LFSR_W-1:0] taps_q, taps_d;
    logic [CNT_W-1:0]  len_q, len_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_q, err_d;
    logic              lfsr_load;
    logic              lfsr_adv;
    logic              fire;
    logic [LFSR_W-1:0] lfsr;

    pn_lfsr #(
        .LFSR_W  (LFSR_W),
        .RST_VAL (DEF_SEED)
    ) u_lfsr (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .load    (lfsr_load),
        .seed    (seed_q),
        .advance (lfsr_adv),
        .taps    (taps_q),
        .state   (lfsr)
    );

    always_comb begin
        state_d   = state_q;
        seed_d    = seed_q;
        taps_d    = taps_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        err_d     = 1'b0;
        lfsr_load = 1'b0;
        lfsr_adv  = 1'b0;

        // Abort also blocks config intake so a held request is not half-applied.
        cfg_ready     = (state_q == ST_IDLE) && !abort;
        chip_valid    = (state_q == ST_RUN);
        fire          = chip_valid && chip_ready;
        chip_out      = chip_valid && lfsr[0];
        period_mark   = chip_valid && (lfsr == seed_q);
        burst_last    = chip_valid && (len_q != '0) && (cnt_q == (len_q - CNT_W'(1)));
        busy          = (state_q != ST_IDLE);
        done          = (state_q == ST_DONE);
        err_seed_zero = err_q;

        if (fire) begin
            lfsr_adv = 1'b1;
            cnt_d    = cnt_q + CNT_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (cfg_valid && cfg_ready) begin
                    if (cfg_seed != '0) begin
                        seed_d = cfg_seed;
                        taps_d = cfg_taps;
                        len_d  = cfg_len;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                if (start) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                lfsr_load = 1'b1;
                cnt_d     = '0;
                state_d   = ST_RUN;
            end
            ST_RUN: begin
                if (fire && burst_last) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (abort) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q <= ST_IDLE;
            seed_q  <= DEF_SEED;
            taps_q  <= DEF_TAPS;
            len_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            seed_q  <= seed_d;
            taps_q  <= taps_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_pn_seq_ctrl.sv
// Directed bench for pn_seq_ctrl; expected chips come from the hand-derived period of seed 0110 / taps 1001.
module tb_pn_seq_ctrl;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [3:0]  cfg_seed;
    logic [3:0]  cfg_taps;
    logic [15:0] cfg_len;
    logic        start;
    logic        abort;
    logic        chip_out;
    logic        chip_valid;
    logic        chip_ready;
    logic        period_mark;
    logic        burst_last;
    logic        busy;
    logic        done;
    logic        err_seed_zero;

    int cmp_cnt = 0;
    int err_cnt = 0;

    // Chip i of the 15-chip period from state 0110 (taps 1001) is pn_tab[i]; state 0001 sits at index 5,
    // state 1010 at index 13.
    logic [14:0] pn_tab = 15'b101111000100110;

    pn_seq_ctrl dut (
        .sys_clk       (sys_clk),
        .sys_rst       (sys_rst),
        .cfg_valid     (cfg_valid),
        .cfg_ready     (cfg_ready),
        .cfg_seed      (cfg_seed),
        .cfg_taps      (cfg_taps),
        .cfg_len       (cfg_len),
        .start         (start),
        .abort         (abort),
        .chip_out      (chip_out),
        .chip_valid    (chip_valid),
        .chip_ready    (chip_ready),
        .period_mark   (period_mark),
        .burst_last    (burst_last),
        .busy          (busy),
        .done          (done),
        .err_seed_zero (err_seed_zero)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        cmp_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_cfg(input logic [3:0] seed, input logic [3:0] taps, input logic [15:0] len,
                          input logic exp_err);
        @(posedge sys_clk); #1;
        cfg_valid = 1'b1;
        cfg_seed  = seed;
        cfg_taps  = taps;
        cfg_len   = len;
        @(negedge sys_clk);
        chk("cfg_ready_idle", {31'd0, cfg_ready}, 32'd1);
        @(posedge sys_clk); #1;
        cfg_valid = 1'b0;
        @(negedge sys_clk);
        chk("err_pulse", {31'd0, err_seed_zero}, {31'd0, exp_err});
        @(negedge sys_clk);
        chk("err_clear", {31'd0, err_seed_zero}, 32'd0);
    endtask

    task automatic do_start();
        @(posedge sys_clk); #1;
        start = 1'b1;
        @(posedge sys_clk); #1;
        start = 1'b0;
    endtask

    task automatic run_chips(input string tag, input int n, input int len, input int off,
                             input int stall_at, input int start_at);
        for (int i = 0; i < n; i++) begin
            int k;
            int idx;
            k = 0;
            idx = (i + off) % 15;
            @(negedge sys_clk);
            start = 1'b0;
            while (!chip_valid && k < 10) begin
                @(negedge sys_clk);
                k++;
            end
            chk({tag, "_valid"}, {31'd0, chip_valid}, 32'd1);
            chk({tag, "_chip"}, {31'd0, chip_out}, {31'd0, pn_tab[idx]});
            chk({tag, "_pmark"}, {31'd0, period_mark}, {31'd0, (i % 15) == 0});
            chk({tag, "_last"}, {31'd0, burst_last}, {31'd0, (len != 0) && (i == len - 1)});
            if (i == stall_at) begin
                chip_ready = 1'b0;
                repeat (3) begin
                    @(negedge sys_clk);
                    chk({tag, "_stall_chip"}, {31'd0, chip_out}, {31'd0, pn_tab[idx]});
                    chk({tag, "_stall_valid"}, {31'd0, chip_valid}, 32'd1);
                    chk({tag, "_stall_cfgrdy"}, {31'd0, cfg_ready}, 32'd0);
                end
                chip_ready = 1'b1;
            end
            if (i == start_at) start = 1'b1;
        end
    endtask

    task automatic check_done(input string tag);
        @(negedge sys_clk);
        chk({tag, "_done"}, {31'd0, done}, 32'd1);
        chk({tag, "_done_novalid"}, {31'd0, chip_valid}, 32'd0);
        @(negedge sys_clk);
        chk({tag, "_done_end"}, {31'd0, done}, 32'd0);
        chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic do_abort(input string tag);
        abort = 1'b1;
        @(negedge sys_clk);
        chk({tag, "_abort_valid"}, {31'd0, chip_valid}, 32'd0);
        chk({tag, "_abort_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_abort_nodone"}, {31'd0, done}, 32'd0);
        abort = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        sys_rst    = 1'b1;
        cfg_valid  = 1'b0;
        cfg_seed   = 4'd0;
        cfg_taps   = 4'd0;
        cfg_len    = 16'd0;
        start      = 1'b0;
        abort      = 1'b0;
        chip_ready = 1'b1;
        repeat (3) @(posedge sys_clk);
        #1 sys_rst = 1'b0;
        @(negedge sys_clk);
        chk("rst_cfg_ready", {31'd0, cfg_ready}, 32'd1);
        chk("rst_outs", {25'd0, chip_out, chip_valid, period_mark, burst_last, busy, done, err_seed_zero},
            32'd0);

        // 1: default seed/taps, 15-chip burst
        do_cfg(4'b0110, 4'b1001, 16'd15, 1'b0);
        do_start();
        run_chips("t1", 15, 15, 0, -1, -1);
        check_done("t1");

        // 2: 20-chip burst wraps the period once
        do_cfg(4'b0110, 4'b1001, 16'd20, 1'b0);
        do_start();
        run_chips("t2", 20, 20, 0, -1, -1);
        check_done("t2");

        // 3: backpressure at chip 4 with the same 20-chip config
        do_start();
        run_chips("t3", 20, 20, 0, 4, -1);
        check_done("t3");

        // 4: zero seed is rejected and the old config still drives the next burst
        do_cfg(4'b0000, 4'b0011, 16'd4, 1'b1);
        do_start();
        run_chips("t4a", 2, 20, 0, -1, -1);
        do_abort("t4a");
        do_cfg(4'b0001, 4'b1001, 16'd4, 1'b0);
        do_start();
        run_chips("t4b", 4, 4, 5, -1, -1);
        check_done("t4b");

        // 5: continuous run, abort after 40 fires, restart reloads the seed
        do_cfg(4'b0001, 4'b1001, 16'd0, 1'b0);
        do_start();
        run_chips("t5", 40, 0, 5, -1, -1);
        do_abort("t5");
        do_start();
        run_chips("t5b", 2, 0, 5, -1, -1);
        do_abort("t5b");

        // 6: config and start together; a start during RUN is ignored
        @(posedge sys_clk); #1;
        cfg_valid = 1'b1;
        cfg_seed  = 4'b1010;
        cfg_taps  = 4'b1001;
        cfg_len   = 16'd5;
        start     = 1'b1;
        @(posedge sys_clk); #1;
        cfg_valid = 1'b0;
        start     = 1'b0;
        run_chips("t6", 5, 5, 13, -1, 2);
        check_done("t6");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
